// File: rtl/ysyx_25040101_lsu_bus.sv
// ysyx_25040101_lsu_bus
//   Multi-cycle load/store unit sitting between the EXU and a valid/ready
//   memory bus. It accepts one byte/half/word(/double) request at a time,
//   issues a word-aligned bus request with byte strobes and lane-shifted
//   store data, waits for the bus response (loads and store acks alike) and
//   returns zero- or sign-extended load data with a one-cycle rsp_valid_o.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o EXU request handshake (ready only while idle)
//   req_we_i            1 = store, 0 = load
//   req_size_i          0 = byte, 1 = half, 2 = word, 3 = double
//   req_sext_i          sign-extend the load result
//   req_addr_i          byte address
//   req_wdata_i         LSB-justified store data
//   rsp_valid_o         one-cycle completion pulse
//   rsp_rdata_o         extended load data (0 for stores and faults)
//   rsp_err_o           fault / bus error, qualified by rsp_valid_o
//   mem_valid_o/ready_i bus request handshake
//   mem_we_o            bus write
//   mem_addr_o          aligned address (lane bits forced to 0)
//   mem_wstrb_o         byte enables (all 0 on reads)
//   mem_wdata_o         store data moved to its byte lanes
//   mem_rvalid_i        bus response valid (read data or write ack)
//   mem_rdata_i         full aligned bus word
//   mem_rerr_i          bus error, qualified by mem_rvalid_i
//
// Configuration
//   LSU_MISALIGN_CHECK_EN  when defined, an address that is not a multiple of
//   the access size faults without touching the bus. When undefined, bytes
//   that run past the end of the aligned word wrap around to lane 0.
module ysyx_25040101_lsu_bus #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_sext_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              rsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN/8-1:0] mem_wstrb_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              mem_rerr_i
);

  localparam int STRB_W = XLEN / 8;
  localparam int LANE_W = $clog2(STRB_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic              we_p0;
  logic [1:0]        size_p0;
  logic              sext_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [XLEN-1:0]   wdata_p0;
  logic [LANE_W-1:0] lane_p0;

  logic [XLEN-1:0]   rdata_p1;
  logic              err_p1;

  logic              size_err;
  logic              misalign;
  logic              req_fault;

  // Byte-enable pattern of an access of 1<<size bytes starting at lane 0.
  function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] size);
    logic [STRB_W-1:0] m;
    for (int i = 0; i < STRB_W; i++) begin
      m[i] = (i < (1 << size));
    end
    return m;
  endfunction

  function automatic logic [XLEN-1:0] byte_expand(input logic [STRB_W-1:0] m);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = m[i/8];
    end
    return r;
  endfunction

  // Rotations rather than shifts so that a misaligned access wraps inside
  // the aligned word; for aligned accesses they behave exactly like shifts.
  function automatic logic [XLEN-1:0] rotl_data(input logic [XLEN-1:0] x,
                                                input logic [LANE_W-1:0] lane);
    logic [2*XLEN-1:0] d;
    d = {x, x} << {lane, 3'b000};
    return d[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] rotr_data(input logic [XLEN-1:0] x,
                                                input logic [LANE_W-1:0] lane);
    logic [2*XLEN-1:0] d;
    d = {x, x} >> {lane, 3'b000};
    return d[XLEN-1:0];
  endfunction

  function automatic logic [STRB_W-1:0] rotl_strb(input logic [STRB_W-1:0] m,
                                                  input logic [LANE_W-1:0] lane);
    logic [2*STRB_W-1:0] d;
    d = {m, m} << lane;
    return d[2*STRB_W-1:STRB_W];
  endfunction

  // Truncate to the access size, then fill the upper bits with zeros or
  // with the top bit of the highest accessed byte.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rot,
                                               input logic [1:0]      size,
                                               input logic            sext);
    logic [STRB_W-1:0] m;
    logic [XLEN-1:0]   r;
    logic              sbit;
    m    = size_mask(size);
    sbit = 1'b0;
    for (int i = 0; i < STRB_W; i++) begin
      if (m[i]) sbit = rot[8*i+7];
    end
    for (int i = 0; i < XLEN; i++) begin
      r[i] = m[i/8] ? rot[i] : (sext & sbit);
    end
    return r;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  function automatic logic [LANE_W-1:0] align_mask(input logic [1:0] size);
    logic [LANE_W-1:0] m;
    for (int i = 0; i < LANE_W; i++) begin
      m[i] = (i < int'(size));
    end
    return m;
  endfunction

  assign misalign = |(req_addr_i[LANE_W-1:0] & align_mask(req_size_i));
`else
  assign misalign = 1'b0;
`endif

  assign size_err  = (XLEN == 32) && (req_size_i == 2'd3);
  assign req_fault = size_err | misalign;
  assign lane_p0   = addr_p0[LANE_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid_i) state_nxt = req_fault ? S_RESP : S_REQ;
      S_REQ:  if (mem_ready_i) state_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid_i) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      err_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_valid_i) begin
        err_p1 <= req_fault;
      end else if (state == S_WAIT && mem_rvalid_i) begin
        err_p1 <= mem_rerr_i;
      end
    end
  end

  // Stage p0: request captured at accept, held through the bus transaction.
  // Stage p1: bus response captured in WAIT, presented during RESP.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid_i) begin
      we_p0    <= req_we_i;
      size_p0  <= req_size_i;
      sext_p0  <= req_sext_i;
      addr_p0  <= req_addr_i;
      wdata_p0 <= req_wdata_i;
    end
    if (state == S_WAIT && mem_rvalid_i) begin
      rdata_p1 <= (we_p0 || mem_rerr_i) ? '0 :
                  load_ext(rotr_data(mem_rdata_i, lane_p0), size_p0, sext_p0);
    end
  end

  // Outputs decode from the state so that reset forces them all to 0.
  assign req_ready_o = (state == S_IDLE);
  assign rsp_valid_o = (state == S_RESP);
  assign rsp_err_o   = (state == S_RESP) && err_p1;
  assign rsp_rdata_o = (state == S_RESP && !err_p1) ? rdata_p1 : '0;

  assign mem_valid_o = (state == S_REQ);
  assign mem_we_o    = (state == S_REQ) && we_p0;
  assign mem_addr_o  = (state == S_REQ) ?
                       {addr_p0[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign mem_wstrb_o = (state == S_REQ && we_p0) ?
                       rotl_strb(size_mask(size_p0), lane_p0) : '0;
  assign mem_wdata_o = (state == S_REQ && we_p0) ?
                       rotl_data(wdata_p0 & byte_expand(size_mask(size_p0)), lane_p0) : '0;

endmodule

// File: tb/tb_ysyx_25040101_lsu_bus.sv
module tb_ysyx_25040101_lsu_bus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic        req_sext_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_valid_o;
  logic        mem_ready_i = 1'b0;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        mem_rerr_i = 1'b0;

  int n_pass = 0;
  int n_tot  = 0;

  ysyx_25040101_lsu_bus #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i), .req_sext_i(req_sext_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_rerr_i(mem_rerr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rerr;
    int          rdly;
    int          vdly;
    logic [31:0] e_rd;
    logic        e_err;
    logic        e_bus;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sext,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic rerr,
                              input int rdly, input int vdly,
                              input logic [31:0] e_rd, input logic e_err, input logic e_bus,
                              input logic [31:0] e_addr, input logic [3:0] e_strb,
                              input logic [31:0] e_wd);
    vec_t v;
    v.we = we; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.rerr = rerr; v.rdly = rdly; v.vdly = vdly;
    v.e_rd = e_rd; v.e_err = e_err; v.e_bus = e_bus; v.e_addr = e_addr;
    v.e_strb = e_strb; v.e_wd = e_wd;
    return v;
  endfunction

  // Reference model: byte i of an access lives in lane (addr+i) mod 4.
  function automatic logic m_bus(input logic [1:0] size, input logic [31:0] addr);
    logic ok;
    ok = (size != 2'd3);
`ifdef LSU_MISALIGN_CHECK_EN
    if (ok && (addr % (32'd1 << size)) != 0) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [3:0] m_strb(input logic we, input logic [1:0] size,
                                        input logic [31:0] addr);
    logic [3:0] r;
    r = 4'b0;
    if (we) for (int i = 0; i < (1 << size); i++) r[(addr[1:0] + i) % 4] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] addr,
                                          input logic [31:0] wd);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < (1 << size); i++) r[8*((addr[1:0] + i) % 4) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sext,
                                         input logic [31:0] addr, input logic [31:0] rd);
    logic [63:0] v;
    int nb;
    nb = 1 << size;
    v = 64'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*((addr[1:0] + i) % 4) +: 8];
    if (sext && v[8*nb-1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
    return v[31:0];
  endfunction

  // Drives one request, plays the memory side and records what the DUT did.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic rerr,
                         input int rdly, input int vdly,
                         output logic rdy0, output int lat, output int nrsp,
                         output logic [31:0] rsp_d, output logic rsp_e,
                         output logic bus, output logic [31:0] maddr,
                         output logic [3:0] mstrb, output logic [31:0] mwd,
                         output logic mwe, output logic bad);
    logic hs, rv_done;
    int vcnt, wcnt;
    @(negedge clk);
    rdy0 = req_ready_o;
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_sext_i = sext;
    req_addr_i = addr; req_wdata_i = wdata;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_we_i = $urandom_range(0, 1); req_size_i = 2'($urandom_range(0, 3));
    req_sext_i = $urandom_range(0, 1); req_addr_i = $urandom; req_wdata_i = $urandom;
    lat = 0; nrsp = 0; bus = 1'b0; bad = 1'b0; hs = 1'b0; rv_done = 1'b0;
    vcnt = 0; wcnt = 0; rsp_d = 32'h0; rsp_e = 1'b0;
    maddr = 32'h0; mstrb = 4'h0; mwd = 32'h0; mwe = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rerr_i = 1'b0;
      if (req_ready_o && (mem_valid_o || rsp_valid_o)) bad = 1'b1;
      if (rsp_valid_o) begin
        nrsp++;
        if (nrsp == 1) begin lat = c; rsp_d = rsp_rdata_o; rsp_e = rsp_err_o; end
      end
      if (mem_valid_o) begin
        if (!bus) begin
          maddr = mem_addr_o; mstrb = mem_wstrb_o; mwd = mem_wdata_o; mwe = mem_we_o;
        end else if (maddr !== mem_addr_o || mstrb !== mem_wstrb_o ||
                     mwd !== mem_wdata_o || mwe !== mem_we_o) begin
          bad = 1'b1;
        end
        bus = 1'b1;
        if (vcnt >= rdly) begin
          mem_ready_i = 1'b1; hs = 1'b1;
        end else begin
          // stray response while the request is still pending: must be ignored
          mem_rvalid_i = 1'b1; mem_rerr_i = 1'b1; mem_rdata_i = $urandom;
        end
        vcnt++;
      end else if (hs && !rv_done) begin
        if (wcnt == vdly) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_rerr_i = rerr; rv_done = 1'b1;
        end
        wcnt++;
      end
      if (nrsp > 0 && c >= lat + 2) break;
    end
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rerr_i = 1'b0;
  endtask

  initial begin
    logic        rdy0, rsp_e, bus, mwe, bad, e_bus, e_err;
    logic [31:0] rsp_d, maddr, mwd, e_rd;
    logic [3:0]  mstrb;
    int          lat, nrsp, rsp_cnt;
    vec_t        v;

    //            we    sz    sx    addr          wdata         rdata         rerr rd vd  e_rd          err   bus   e_addr        strb     e_wd
    tv[0]  = mk(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h8000_0004, 4'b0000, 32'h0);
    tv[1]  = mk(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0,        32'h80FF_0000, 1'b0, 0, 0, 32'hFFFF_FF80, 1'b0, 1'b1, 32'h8000_0000, 4'b0000, 32'h0);
    tv[2]  = mk(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0,        32'h80FF_0000, 1'b0, 0, 0, 32'h0000_0080, 1'b0, 1'b1, 32'h8000_0000, 4'b0000, 32'h0);
    tv[3]  = mk(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 32'h0,        1'b0, 0, 0, 32'h0,         1'b0, 1'b1, 32'h8000_0000, 4'b1100, 32'hABCD_0000);
    tv[4]  = mk(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0,        32'h1357_9BDF, 1'b0, 5, 2, 32'h1357_9BDF, 1'b0, 1'b1, 32'h8000_0008, 4'b0000, 32'h0);
    tv[5]  = mk(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,        32'h5555_AAAA, 1'b1, 0, 0, 32'h0,         1'b1, 1'b1, 32'h8000_0010, 4'b0000, 32'h0);
    tv[6]  = mk(1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0,        32'h80FF_1234, 1'b0, 0, 1, 32'hFFFF_80FF, 1'b0, 1'b1, 32'h8000_0000, 4'b0000, 32'h0);
    tv[7]  = mk(1'b0, 2'd1, 1'b0, 32'h8000_0000, 32'h0,        32'h80FF_1234, 1'b0, 1, 0, 32'h0000_1234, 1'b0, 1'b1, 32'h8000_0000, 4'b0000, 32'h0);
    tv[8]  = mk(1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'hFFFF_FFA5, 32'h0,        1'b0, 0, 0, 32'h0,         1'b0, 1'b1, 32'h8000_0000, 4'b0010, 32'h0000_A500);
    tv[9]  = mk(1'b1, 2'd2, 1'b0, 32'h8000_000C, 32'hCAFE_F00D, 32'h0,        1'b0, 2, 3, 32'h0,         1'b0, 1'b1, 32'h8000_000C, 4'b1111, 32'hCAFE_F00D);
    tv[10] = mk(1'b0, 2'd3, 1'b0, 32'h8000_0020, 32'h0,        32'h0,         1'b0, 0, 0, 32'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 32'h0);
    tv[11] = mk(1'b1, 2'd2, 1'b0, 32'h8000_0014, 32'h0000_0001, 32'h0,        1'b1, 0, 0, 32'h0,         1'b1, 1'b1, 32'h8000_0014, 4'b1111, 32'h0000_0001);
`ifdef LSU_MISALIGN_CHECK_EN
    tv[12] = mk(1'b0, 2'd1, 1'b1, 32'h8000_0003, 32'h0,        32'h1122_3344, 1'b0, 0, 0, 32'h0,         1'b1, 1'b0, 32'h0,         4'b0000, 32'h0);
`else
    tv[12] = mk(1'b0, 2'd1, 1'b1, 32'h8000_0003, 32'h0,        32'h1122_3344, 1'b0, 0, 0, 32'h0000_4411, 1'b0, 1'b1, 32'h8000_0000, 4'b0000, 32'h0);
`endif

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_mem_bus", {mem_we_o, mem_addr_o, mem_wstrb_o}, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      v = tv[i];
      run_txn(v.we, v.size, v.sext, v.addr, v.wdata, v.rdata, v.rerr, v.rdly, v.vdly,
              rdy0, lat, nrsp, rsp_d, rsp_e, bus, maddr, mstrb, mwd, mwe, bad);
      chk($sformatf("v%0d_ready", i), rdy0, 1);
      chk($sformatf("v%0d_nrsp", i), nrsp, 1);
      chk($sformatf("v%0d_rdata", i), rsp_d, v.e_rd);
      chk($sformatf("v%0d_err", i), rsp_e, v.e_err);
      chk($sformatf("v%0d_bus", i), bus, v.e_bus);
      chk($sformatf("v%0d_hold", i), bad, 0);
      if (v.e_bus) begin
        chk($sformatf("v%0d_lat", i), lat, 3 + v.rdly + v.vdly);
        chk($sformatf("v%0d_addr", i), maddr, v.e_addr);
        chk($sformatf("v%0d_we", i), mwe, v.we);
        chk($sformatf("v%0d_strb", i), mstrb, v.e_strb);
        if (v.we) chk($sformatf("v%0d_wdata", i), mwd, v.e_wd);
      end else begin
        chk($sformatf("v%0d_fault_lat", i), (lat >= 1 && lat <= 2), 1);
      end
    end

    // randomized transactions against the reference model
    for (int i = 0; i < 60; i++) begin
      v.we = $urandom_range(0, 1); v.size = 2'($urandom_range(0, 3));
      v.sext = $urandom_range(0, 1); v.addr = $urandom; v.wdata = $urandom;
      v.rdata = $urandom; v.rerr = ($urandom_range(0, 7) == 0);
      v.rdly = $urandom_range(0, 3); v.vdly = $urandom_range(0, 3);
      e_bus = m_bus(v.size, v.addr);
      e_err = !e_bus || v.rerr;
      e_rd  = (e_err || v.we) ? 32'h0 : m_load(v.size, v.sext, v.addr, v.rdata);
      run_txn(v.we, v.size, v.sext, v.addr, v.wdata, v.rdata, v.rerr, v.rdly, v.vdly,
              rdy0, lat, nrsp, rsp_d, rsp_e, bus, maddr, mstrb, mwd, mwe, bad);
      chk($sformatf("r%0d_nrsp", i), nrsp, 1);
      chk($sformatf("r%0d_rdata", i), rsp_d, e_rd);
      chk($sformatf("r%0d_err", i), rsp_e, e_err);
      chk($sformatf("r%0d_bus", i), bus, e_bus);
      chk($sformatf("r%0d_hold", i), bad, 0);
      if (e_bus) begin
        chk($sformatf("r%0d_lat", i), lat, 3 + v.rdly + v.vdly);
        chk($sformatf("r%0d_addr", i), maddr, {v.addr[31:2], 2'b00});
        chk($sformatf("r%0d_strb", i), mstrb, m_strb(v.we, v.size, v.addr));
        if (v.we) chk($sformatf("r%0d_wdata", i), mwd, m_wdata(v.size, v.addr, v.wdata));
      end
    end

    // reset while waiting for the bus response, then a stray response
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h8000_0040;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(negedge clk);
    chk("wr_mem_valid", mem_valid_o, 1);
    mem_ready_i = 1'b1;
    @(posedge clk);
    #1 mem_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wr_req_ready", req_ready_o, 1);
    chk("wr_mem_valid0", mem_valid_o, 0);
    chk("wr_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 0);
    chk("wr_mem_bus", {mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    rsp_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid_o) rsp_cnt++;
    end
    chk("wr_stray_rsp", rsp_cnt, 0);
    chk("wr_idle_ready", req_ready_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
